// File: rtl/mem_port_arbiter_if.sv
// Request/response bundle for the fetch (I) and load/store (D) ports of the memory arbiter.
// The requester side uses the master modport; the arbiter uses the slave modport.
interface mem_port_arbiter_if;
  logic        i_req_valid;
  logic [31:0] i_req_addr;
  logic        i_req_ready;
  logic        i_rsp_valid;
  logic [31:0] i_rsp_data;

  logic        d_req_valid;
  logic [31:0] d_req_addr;
  logic        d_req_we;
  logic [31:0] d_req_wdata;
  logic        d_req_ready;
  logic        d_rsp_valid;
  logic [31:0] d_rsp_data;

  modport master (
    output i_req_valid, i_req_addr,
    input  i_req_ready, i_rsp_valid, i_rsp_data,
    output d_req_valid, d_req_addr, d_req_we, d_req_wdata,
    input  d_req_ready, d_rsp_valid, d_rsp_data
  );

  modport slave (
    input  i_req_valid, i_req_addr,
    output i_req_ready, i_rsp_valid, i_rsp_data,
    input  d_req_valid, d_req_addr, d_req_we, d_req_wdata,
    output d_req_ready, d_rsp_valid, d_rsp_data
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter: D has priority, a saturating starvation counter bounds I's wait.
// One grant per cycle; read data is registered into a one-cycle-latency response on the winning port.
module mem_port_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  mem_port_arbiter_if.slave   bus,
  output logic [31:0]         mem_address,
  output logic [31:0]         mem_write_data,
  output logic                mem_write_enable,
  input  logic [31:0]         mem_read_data,
  output logic [1:0]          arb_owner
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SERV_I = 2'b01,
    SERV_D = 2'b10
  } owner_e;

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  generate
    if ((2 ** CNT_W) <= STARVE_LIMIT) begin : g_bad_cnt_w
      $error("CNT_W too narrow to hold STARVE_LIMIT");
    end
  endgenerate

  owner_e           state;
  logic [CNT_W-1:0] starve_cnt;
  logic             force_i;
  logic             gnt_i;
  logic             gnt_d;

  // NOTE: every signal gets a value before any condition so this block stays purely
  // combinational; a missing default on some path would infer a latch.
  always_comb begin
    force_i     = bus.i_req_valid && (starve_cnt >= LIMIT);
    gnt_i       = rst_n && bus.i_req_valid && (!bus.d_req_valid || force_i);
    gnt_d       = rst_n && bus.d_req_valid && !gnt_i;
    mem_address = 32'h0;
    if (gnt_i) begin
      mem_address = bus.i_req_addr;
    end else if (gnt_d) begin
      mem_address = bus.d_req_addr;
    end
  end

  assign bus.i_req_ready   = gnt_i;
  assign bus.d_req_ready   = gnt_d;
  assign mem_write_data    = bus.d_req_wdata;
  // Qualified by rst_n so an accepted store is dropped if reset lands before the edge.
  assign mem_write_enable  = gnt_d && bus.d_req_we && rst_n;
  assign arb_owner         = state;

  // NOTE: state uses non-blocking assignments so all registers update from the
  // same pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      starve_cnt      <= '0;
      bus.i_rsp_valid <= 1'b0;
      bus.d_rsp_valid <= 1'b0;
      bus.i_rsp_data  <= 32'h0;
      bus.d_rsp_data  <= 32'h0;
    end else begin
      bus.i_rsp_valid <= gnt_i;
      bus.d_rsp_valid <= gnt_d;

      if (gnt_i) begin
        state          <= SERV_I;
        bus.i_rsp_data <= mem_read_data;
      end else if (gnt_d) begin
        state          <= SERV_D;
        bus.d_rsp_data <= bus.d_req_we ? 32'h0 : mem_read_data;
      end else begin
        state <= IDLE;
      end

      if (!bus.i_req_valid || gnt_i) begin
        starve_cnt <= '0;
      end else if (starve_cnt < LIMIT) begin
        starve_cnt <= starve_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a word-addressed memory model behind the memory port.
// Inputs change just after the rising edge; outputs are checked at the falling edge.
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst_n;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic        mem_write_enable;
  logic [31:0] mem_read_data;
  logic [1:0]  arb_owner;

  logic [31:0] mem [0:63];

  int total;
  int bad;

  mem_port_arbiter_if bus ();

  mem_port_arbiter #(
    .STARVE_LIMIT (4),
    .CNT_W        (3)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .bus              (bus.slave),
    .mem_address      (mem_address),
    .mem_write_data   (mem_write_data),
    .mem_write_enable (mem_write_enable),
    .mem_read_data    (mem_read_data),
    .arb_owner        (arb_owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_read_data = mem[mem_address[7:2]];

  always @(posedge clk) begin
    if (mem_write_enable) mem[mem_address[7:2]] <= mem_write_data;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %08h expected %08h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.i_req_valid = 1'b0;
    bus.i_req_addr  = 32'h0;
    bus.d_req_valid = 1'b0;
    bus.d_req_addr  = 32'h0;
    bus.d_req_we    = 1'b0;
    bus.d_req_wdata = 32'h0;
  endtask

  logic [31:0] stream_exp [0:3];

  initial begin
    total = 0;
    bad   = 0;
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    mem[0] = 32'hDEADBEEF;
    mem[1] = 32'h12345678;
    mem[2] = 32'hABCDEF01;
    mem[3] = 32'hFEDCBA98;
    stream_exp[0] = 32'hDEADBEEF;
    stream_exp[1] = 32'h12345678;
    stream_exp[2] = 32'hABCDEF01;
    stream_exp[3] = 32'hFEDCBA98;

    // Reset: requests present but nothing may be granted or written.
    rst_n = 1'b0;
    idle_inputs();
    bus.d_req_valid = 1'b1;
    bus.d_req_we    = 1'b1;
    bus.i_req_valid = 1'b1;
    @(negedge clk);
    check("rst_i_rsp_valid", 32'(bus.i_rsp_valid), 32'd0);
    check("rst_d_rsp_valid", 32'(bus.d_rsp_valid), 32'd0);
    check("rst_i_rsp_data",  bus.i_rsp_data, 32'h0);
    check("rst_d_rsp_data",  bus.d_rsp_data, 32'h0);
    check("rst_owner",       32'(arb_owner), 32'd0);
    check("rst_mem_we",      32'(mem_write_enable), 32'd0);
    check("rst_i_ready",     32'(bus.i_req_ready), 32'd0);
    check("rst_d_ready",     32'(bus.d_req_ready), 32'd0);
    idle_inputs();
    rst_n = 1'b1;

    // Single fetch of 0x0 with D idle.
    step();
    bus.i_req_valid = 1'b1;
    bus.i_req_addr  = 32'h0;
    @(negedge clk);
    check("f1_i_ready", 32'(bus.i_req_ready), 32'd1);
    check("f1_d_ready", 32'(bus.d_req_ready), 32'd0);
    check("f1_addr",    mem_address, 32'h0);
    step();
    idle_inputs();
    @(negedge clk);
    check("f1_i_rsp_valid", 32'(bus.i_rsp_valid), 32'd1);
    check("f1_i_rsp_data",  bus.i_rsp_data, 32'hDEADBEEF);
    check("f1_d_rsp_valid", 32'(bus.d_rsp_valid), 32'd0);
    check("f1_owner",       32'(arb_owner), 32'd1);

    // Both valid: D load 0x4 wins, I wins once D drops.
    step();
    bus.i_req_valid = 1'b1;
    bus.i_req_addr  = 32'h0;
    bus.d_req_valid = 1'b1;
    bus.d_req_addr  = 32'h4;
    @(negedge clk);
    check("pr_d_ready", 32'(bus.d_req_ready), 32'd1);
    check("pr_i_ready", 32'(bus.i_req_ready), 32'd0);
    check("pr_addr",    mem_address, 32'h4);
    check("pr_idle_rsp", 32'(bus.i_rsp_valid), 32'd0);
    step();
    bus.d_req_valid = 1'b0;
    @(negedge clk);
    check("pr_d_rsp_valid", 32'(bus.d_rsp_valid), 32'd1);
    check("pr_d_rsp_data",  bus.d_rsp_data, 32'h12345678);
    check("pr_owner_d",     32'(arb_owner), 32'd2);
    check("pr_i_ready2",    32'(bus.i_req_ready), 32'd1);
    step();
    idle_inputs();
    @(negedge clk);
    check("pr_i_rsp_valid", 32'(bus.i_rsp_valid), 32'd1);
    check("pr_i_rsp_data",  bus.i_rsp_data, 32'hDEADBEEF);
    check("pr_d_rsp_low",   32'(bus.d_rsp_valid), 32'd0);

    // Store 0x78 then load it back.
    step();
    bus.d_req_valid = 1'b1;
    bus.d_req_addr  = 32'h78;
    bus.d_req_we    = 1'b1;
    bus.d_req_wdata = 32'h11223344;
    @(negedge clk);
    check("st_d_ready", 32'(bus.d_req_ready), 32'd1);
    check("st_mem_we",  32'(mem_write_enable), 32'd1);
    check("st_wdata",   mem_write_data, 32'h11223344);
    step();
    bus.d_req_we    = 1'b0;
    bus.d_req_wdata = 32'h0;
    @(negedge clk);
    check("st_ack_valid", 32'(bus.d_rsp_valid), 32'd1);
    check("st_ack_data",  bus.d_rsp_data, 32'h0);
    check("ld_mem_we",    32'(mem_write_enable), 32'd0);
    step();
    idle_inputs();
    @(negedge clk);
    check("ld_valid", 32'(bus.d_rsp_valid), 32'd1);
    check("ld_data",  bus.d_rsp_data, 32'h11223344);
    step();
    @(negedge clk);
    check("hold_valid", 32'(bus.d_rsp_valid), 32'd0);
    check("hold_data",  bus.d_rsp_data, 32'h11223344);
    check("hold_owner", 32'(arb_owner), 32'd0);
    check("idle_addr",  mem_address, 32'h0);

    // Starvation: D continuous, I granted on its 5th waiting cycle.
    for (int k = 1; k <= 5; k++) begin
      step();
      bus.d_req_valid = 1'b1;
      bus.d_req_addr  = 32'h4;
      bus.i_req_valid = 1'b1;
      bus.i_req_addr  = 32'h8;
      @(negedge clk);
      check($sformatf("sv_i_ready_%0d", k), 32'(bus.i_req_ready), (k == 5) ? 32'd1 : 32'd0);
      check($sformatf("sv_d_ready_%0d", k), 32'(bus.d_req_ready), (k == 5) ? 32'd0 : 32'd1);
    end
    step();
    bus.i_req_valid = 1'b0;
    @(negedge clk);
    check("sv_d_regrant",   32'(bus.d_req_ready), 32'd1);
    check("sv_i_rsp_valid", 32'(bus.i_rsp_valid), 32'd1);
    check("sv_i_rsp_data",  bus.i_rsp_data, 32'hABCDEF01);
    step();
    bus.i_req_valid = 1'b1;
    @(negedge clk);
    check("sv_cnt_cleared", 32'(bus.i_req_ready), 32'd0);
    check("sv_owner_d",     32'(arb_owner), 32'd2);
    step();
    idle_inputs();
    step();

    // Reset mid-cycle after a store is accepted, with a fetch response showing.
    bus.i_req_valid = 1'b1;
    bus.i_req_addr  = 32'h0;
    step();
    idle_inputs();
    bus.d_req_valid = 1'b1;
    bus.d_req_addr  = 32'h80;
    bus.d_req_we    = 1'b1;
    bus.d_req_wdata = 32'h55AA55AA;
    #2;
    check("mr_pre_we",        32'(mem_write_enable), 32'd1);
    check("mr_pre_i_rsp",     32'(bus.i_rsp_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mr_i_rsp_valid", 32'(bus.i_rsp_valid), 32'd0);
    check("mr_d_rsp_valid", 32'(bus.d_rsp_valid), 32'd0);
    check("mr_owner",       32'(arb_owner), 32'd0);
    check("mr_mem_we",      32'(mem_write_enable), 32'd0);
    check("mr_d_ready",     32'(bus.d_req_ready), 32'd0);
    step();
    check("mr_no_write", mem[32], 32'h0);
    idle_inputs();
    rst_n = 1'b1;
    step();

    // Back-to-back fetch stream.
    for (int c = 0; c < 5; c++) begin
      if (c < 4) begin
        bus.i_req_valid = 1'b1;
        bus.i_req_addr  = 32'(4 * c);
      end else begin
        bus.i_req_valid = 1'b0;
      end
      @(negedge clk);
      if (c < 4) check($sformatf("bs_ready_%0d", c), 32'(bus.i_req_ready), 32'd1);
      check($sformatf("bs_valid_%0d", c), 32'(bus.i_rsp_valid), (c >= 1) ? 32'd1 : 32'd0);
      if (c >= 1) check($sformatf("bs_data_%0d", c), bus.i_rsp_data, stream_exp[c-1]);
      step();
    end
    @(negedge clk);
    check("bs_end_valid", 32'(bus.i_rsp_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
